// File: rtl/buff_uart_pkg.sv
// Shared types for the buffered UART transmitter.
// State encoding and line levels used by buff_uart_tx.
package buff_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Ring-buffer byte queue feeding the UART serializer.
// Push while full is dropped; push and pop may share an edge.
module uart_tx_fifo
  import buff_uart_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   size_q, size_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (size_q == (AW+1)'(DEPTH));
  assign empty_o = (size_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state from accepted push/pop.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    size_d = size_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    if (push_ok && !pop_ok)      size_d = size_q + 1'b1;
    else if (!push_ok && pop_ok) size_d = size_q - 1'b1;
  end

  // Storage and pointer registers; reset clears the whole queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      size_q <= '0;
    end else begin
      if (push_ok) mem_q[wr_q] <= data_i;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      size_q <= size_d;
    end
  end

endmodule

// File: rtl/buff_uart_tx.sv
// Buffered UART transmitter: byte FIFO plus 8N1 serializer.
// Define BUFF_UART_TX_PARITY_EN for 8E1 frames (even parity bit).
module buff_uart_tx
  import buff_uart_pkg::*;
#(
  parameter int data_width           = 8,
  parameter int length_as_power_of_2 = 4,
  parameter int clocks_per_bit       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  write_enable,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  tx
);

  localparam int BW = $clog2(clocks_per_bit);
  localparam int CW = $clog2(data_width + 1);

  tx_state_t             state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  pop;
  logic [data_width-1:0] head;
  logic                  baud_last;
  logic                  bit_last;
`ifdef BUFF_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  uart_tx_fifo #(
    .DW (data_width),
    .AW (length_as_power_of_2)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (write_enable),
    .data_i  (data_in),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign baud_last = (baud_q == BW'(clocks_per_bit - 1));
  assign bit_last  = (bit_q == CW'(data_width - 1));
  assign tx        = tx_q;
  assign busy      = busy_q;

  // Serializer next state; tx is computed for the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef BUFF_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        tx_d   = UART_IDLE_LEVEL;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = TX_START;
          tx_d    = UART_START_LEVEL;
`ifdef BUFF_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_last) begin
`ifdef BUFF_UART_TX_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef BUFF_UART_TX_PARITY_EN
      TX_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = TX_STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif
      TX_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = TX_START;
            tx_d    = UART_START_LEVEL;
`ifdef BUFF_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = TX_IDLE;
            tx_d    = UART_IDLE_LEVEL;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = TX_IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  // Serializer registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef BUFF_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef BUFF_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
